mesh_seq_ctrl: RTL and testbench

Sequencer for the N×N 2D-mesh matrix multiplier built from 12-bit accumulating PE registers. On START it clears the accumulators, feeds skewed operand indices for A rows and B columns at the mesh edges, and holds the accumulators while data propagates. It then streams the N² results out row-major over a valid/ready handshake. It sits between the operand memories, the mesh, and the result consumer.

---
 rtl/mesh_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mesh_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mesh_seq_ctrl.sv
// Sequencer for an NxN systolic mesh: skewed operand feed, accumulate
// window, then row-major result readout over a valid/ready handshake.
module mesh_seq_ctrl #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          ACC_EN,
    output logic [N*IW-1:0] A_IDX,
    output logic [N-1:0]  A_VLD,
    output logic [N*IW-1:0] B_IDX,
    output logic [N-1:0]  B_VLD,
    output logic [IW-1:0] RD_ROW,
    output logic [IW-1:0] RD_COL,
    output logic          RD_VLD,
    input  logic          RD_RDY,
    output logic          BUSY,
    output logic          DONE
);

    localparam int TW = $clog2(3 * N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [TW-1:0] T_LAST   = TW'(3 * N - 3);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;

    logic in_comp;
    logic in_read;
    logic in_done;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            S_IDLE: begin
                t_d   = '0;
                row_d = '0;
                col_d = '0;
                if (START) begin
                    state_d = S_COMP;
                end
            end
            S_COMP: begin
                if (t_q == T_LAST) begin
                    state_d = S_READ;
                    t_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_READ: begin
                // RD_VLD is implied by the state, so RD_RDY alone accepts
                if (RD_RDY) begin
                    if (col_q == IDX_LAST) begin
                        col_d = '0;
                        if (row_q == IDX_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + IW'(1);
                        end
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign in_comp = (state_q == S_COMP);
    assign in_read = (state_q == S_READ);
    assign in_done = (state_q == S_DONE);

    assign ACC_EN = in_comp | in_read;
    assign BUSY   = in_comp | in_read;
    assign DONE   = in_done;
    assign RD_VLD = in_read;
    // row_q is left at N-1 in DONE, so gate the select with the state
    assign RD_ROW = in_read ? row_q : '0;
    assign RD_COL = in_read ? col_q : '0;

    always_comb begin
        A_VLD = '0;
        A_IDX = '0;
        for (int i = 0; i < N; i++) begin
            if (in_comp && (t_q >= TW'(i)) && (t_q < TW'(i + N))) begin
                A_VLD[i]           = 1'b1;
                A_IDX[i*IW +: IW]  = IW'(t_q - TW'(i));
            end
        end
    end

    // Column skew is identical to row skew: both lag the step count by index
    assign B_VLD = A_VLD;
    assign B_IDX = A_IDX;

endmodule

// File: tb/tb_mesh_seq_ctrl.sv
// Directed bench for mesh_seq_ctrl at N=3: reset, skew, readout,
// backpressure, ignored START and mid-run reset abort.
module tb_mesh_seq_ctrl;

    localparam int N  = 3;
    localparam int IW = 2;

    logic          CLK;
    logic          RST;
    logic          START;
    logic          ACC_EN;
    logic [N*IW-1:0] A_IDX;
    logic [N-1:0]  A_VLD;
    logic [N*IW-1:0] B_IDX;
    logic [N-1:0]  B_VLD;
    logic [IW-1:0] RD_ROW;
    logic [IW-1:0] RD_COL;
    logic          RD_VLD;
    logic          RD_RDY;
    logic          BUSY;
    logic          DONE;

    int n_chk;
    int n_fail;

    // Hand-derived skew for N=3 over t=0..6 (A_IDX packed row2,row1,row0)
    int vld_t[7] = '{1, 3, 7, 6, 4, 0, 0};
    int idx_t[7] = '{0, 1, 6, 24, 32, 0, 0};

    mesh_seq_ctrl #(.N(N), .IW(IW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .ACC_EN (ACC_EN),
        .A_IDX  (A_IDX),
        .A_VLD  (A_VLD),
        .B_IDX  (B_IDX),
        .B_VLD  (B_VLD),
        .RD_ROW (RD_ROW),
        .RD_COL (RD_COL),
        .RD_VLD (RD_VLD),
        .RD_RDY (RD_RDY),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int all_outs();
        return int'({ACC_EN, A_VLD, B_VLD, A_IDX, B_IDX,
                     RD_ROW, RD_COL, RD_VLD, BUSY, DONE});
    endfunction

    task automatic do_run(input bit spam, input bit stall);
        START  = 1'b1;
        RD_RDY = 1'b1;
        tick();
        START = spam;
        for (int t = 0; t < 3 * N - 2; t++) begin
            chk("comp_acc", int'(ACC_EN), 1);
            chk("comp_busy", int'(BUSY), 1);
            chk("comp_rdvld", int'(RD_VLD), 0);
            chk("a_vld", int'(A_VLD), vld_t[t]);
            chk("b_vld", int'(B_VLD), vld_t[t]);
            chk("a_idx", int'(A_IDX), idx_t[t]);
            chk("b_idx", int'(B_IDX), idx_t[t]);
            tick();
        end
        for (int k = 0; k < N * N; k++) begin
            if (stall && k == 4) begin
                RD_RDY = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("stall_row", int'(RD_ROW), 1);
                    chk("stall_col", int'(RD_COL), 1);
                    chk("stall_vld", int'(RD_VLD), 1);
                    tick();
                end
                RD_RDY = 1'b1;
            end
            chk("rd_row", int'(RD_ROW), k / N);
            chk("rd_col", int'(RD_COL), k % N);
            chk("rd_vld", int'(RD_VLD), 1);
            chk("rd_acc", int'(ACC_EN), 1);
            chk("rd_busy", int'(BUSY), 1);
            tick();
        end
        chk("done", int'(DONE), 1);
        chk("done_busy", int'(BUSY), 0);
        chk("done_acc", int'(ACC_EN), 0);
        chk("done_rdvld", int'(RD_VLD), 0);
        tick();
        START = 1'b0;
        chk("idle_done", int'(DONE), 0);
        chk("idle_busy", int'(BUSY), 0);
        chk("idle_acc", int'(ACC_EN), 0);
        tick();
        chk("idle2_busy", int'(BUSY), 0);
        chk("idle2_avld", int'(A_VLD), 0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        RST    = 1'b0;
        START  = 1'b0;
        RD_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            START  = ~START;
            RD_RDY = ~RD_RDY;
            tick();
            chk("rst_outs", all_outs(), 0);
        end
        RST = 1'b1;

        do_run(1'b0, 1'b0);
        do_run(1'b0, 1'b1);
        do_run(1'b1, 1'b0);

        START = 1'b1;
        tick();
        START = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
        end
        chk("pre_abort_avld", int'(A_VLD), 4);
        #2;
        RST = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 0);
        tick();
        chk("abort_hold", all_outs(), 0);
        RST = 1'b1;
        do_run(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
